stream_mux_rr: RTL
==================

// Module: stream_mux_rr
// PURPOSE
//  N-channel streaming mux with valid/ready handshake, round-robin arbitration and
//  a registered output stage. Successor to the combinational one-hot mux: same
//  concatenated input bus, but selection is internal, fair and back-pressured.
//  Sits in front of shared sinks (single-port memory, link TX) fed by several sources.
// PARAMETERS
//  DW  8  data width per channel, >=1
//  N   4  number of input channels, >=2
//  (localparam SW = $clog2(N), pointer width)
// PORTS
//  clk        in   1     clock, all logic on rising edge
//  reset      in   1     synchronous, active-high reset
//  in_valid   in   N     per-channel valid
//  in_data    in   N*DW  concatenated {..,in1[DW-1:0],in0[DW-1:0]}
//  in_ready   out  N     per-channel ready; one-hot or zero
//  out_valid  out  1     registered output valid
//  out_data   out  DW    registered output data
//  out_sel    out  N     one-hot source of current out_data
//  out_ready  in   1     downstream ready
//  in_last    in   N     [STREAM_MUX_PKT_LOCK_EN only] per-channel end of packet
//  out_last   out  1     [STREAM_MUX_PKT_LOCK_EN only] registered last of out beat
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_sel=0, out_last=0, ptr=N-1 (ch0 wins first).
//    in_ready=0 during reset. Reset mid-transfer drops the held beat.
//  - load = ~out_valid | out_ready. in_ready[i] = load & grant[i]. Transfer on ch i
//    when in_valid[i] & in_ready[i]. No combinational path in_valid->out_valid.
//  - Grant: first requesting channel searching ptr+1, ptr+2, .. wrapping modulo N;
//    grant = 0 when no in_valid. Grant depends only on in_valid and registered state.
//  - On transfer: out_data<=in_data[i], out_sel<=onehot(i), out_valid<=1, ptr<=i.
//    If load & no request: out_valid<=0. If ~load: all output regs hold.
//  - Latency 1 cycle in->out; throughput 1 beat/cycle with out_ready held high.
//  - Fairness: with all N channels continuously valid, grant order is
//    0,1,..,N-1,0,..; no channel waits more than N-1 accepted beats.
//  - ptr wraps N-1 -> 0; for non-power-of-2 N, ptr values >=N never occur.
//  - Sources may drop in_valid without transfer; arbiter re-evaluates every cycle.
// CONFIGURATION
//  STREAM_MUX_PKT_LOCK_EN defined: adds in_last/out_last. After a transfer with
//   in_last[i]=0, lock<=1 and grant is forced to ch i (others in_ready=0) until a
//   transfer with in_last[i]=1 clears lock; ptr advances only on that last beat.
//   Locked channel deasserting in_valid stalls the mux (no re-arbitration).
//   out_last<=in_last[i] on transfer. Reset clears lock.
//  Not defined: no lock, no last ports; every beat is arbitrated independently.
// STRUCTURE
//  - Package stream_mux_pkg: function rr_onehot(req,ptr) and onehot2bin; no typedefs.
//  - Sub-module rr_arbiter #(N): comb. req[N], ptr[SW], lock, lock_id -> grant[N],
//    grant_id[SW]. Top holds ptr/lock regs, data mux (AND-OR with grant), out regs.
// TESTING  (N=4, DW=8 unless noted)
//  - Reset: assert reset 3 cycles with in_valid=4'hF -> out_valid=0, in_ready=0,
//    out_sel=0; first grant after release is ch0.
//  - Round robin: all valid, out_ready=1, data ch_i=8'hA0+i -> out_data sequence
//    A0,A1,A2,A3,A0 on consecutive cycles, out_sel 1,2,4,8,1.
//  - Backpressure: out_ready=0 for 5 cycles with beat 8'h55 held -> out_data stays
//    55, in_ready=0; on out_ready=1 next beat issues same cycle (no bubble).
//  - Sparse/wrap: only ch3 then ch1 valid, ptr=2 -> ch3 granted, then ch1; with
//    N=3 all valid -> 0,1,2,0 (no ptr value 3).
//  - Idle: no in_valid, out_ready=1 -> out_valid drops next cycle, out_data holds.
//  - PKT_LOCK_EN: ch1 sends 3-beat packet (last on beat 3) while ch0,ch2 valid ->
//    out_sel=2 for 3 beats, out_last=1 on third, then ch2 granted.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: round-robin search and one-hot decode helpers for stream_mux_rr.
// Both helpers work on 32-bit vectors, so the supported channel count is at most 32.
package stream_mux_pkg;

   function automatic logic [31:0] rr_onehot(input logic [31:0] req, input logic [31:0] ptr, input int n);
      logic [31:0] g;
      int idx;
      g = '0;
      // Walk from the farthest slot back to ptr+1 so the nearest requester is written last.
      for (int k = n; k >= 1; k--) begin
         idx = (int'(ptr) + k) % n;
         if (req[idx]) g = 32'(1) << idx;
      end
      return g;
   endfunction

   function automatic int onehot2bin(input logic [31:0] oh);
      int b;
      b = 0;
      for (int i = 0; i < 32; i++) if (oh[i]) b = i;
      return b;
   endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with an optional packet lock.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   input  logic          lock,
   input  logic [SW-1:0] lock_id,
   output logic [N-1:0]  grant,
   output logic [SW-1:0] grant_id
);
   logic [N-1:0] w_rr;
   logic [N-1:0] w_lk;
   assign w_rr     = N'(rr_onehot(32'(req), 32'(ptr), N));
   // A locked channel is granted only while it requests; otherwise the mux stalls.
   assign w_lk     = req & N'(32'(1) << lock_id);
   assign grant    = lock ? w_lk : w_rr;
   assign grant_id = SW'(onehot2bin(32'(grant)));
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready mux with round-robin arbitration and registered output.
// Define STREAM_MUX_PKT_LOCK_EN to add in_last/out_last and hold the grant for a whole packet.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int DW = 8,
   parameter int N  = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    in_valid,
   input  logic [N*DW-1:0] in_data,
   output logic [N-1:0]    in_ready,
   output logic            out_valid,
   output logic [DW-1:0]   out_data,
   output logic [N-1:0]    out_sel,
`ifdef STREAM_MUX_PKT_LOCK_EN
   input  logic [N-1:0]    in_last,
   output logic            out_last,
`endif
   input  logic            out_ready
);
   localparam int SW = $clog2(N);
   logic            r_out_valid;
   logic [DW-1:0]   r_out_data;
   logic [N-1:0]    r_out_sel;
   logic [SW-1:0]   r_ptr;
   logic            w_load;
   logic            w_xfer;
   logic            w_in_last;
   logic            w_lock;
   logic [SW-1:0]   w_lock_id;
   logic [N-1:0]    w_grant;
   logic [SW-1:0]   w_gid;
   logic [DW-1:0]   w_data;

   rr_arbiter #(.N(N), .SW(SW)) u_arb (
      .req      (in_valid),
      .ptr      (r_ptr),
      .lock     (w_lock),
      .lock_id  (w_lock_id),
      .grant    (w_grant),
      .grant_id (w_gid)
   );

   assign w_load   = ~r_out_valid | out_ready;
   assign in_ready = (w_load & ~reset) ? w_grant : '0;
   assign w_xfer   = w_load & (|w_grant);

   always_comb begin
      w_data = '0;
      for (int i = 0; i < N; i++) w_data = w_data | (in_data[i*DW +: DW] & {DW{w_grant[i]}});
   end

`ifdef STREAM_MUX_PKT_LOCK_EN
   logic          r_lock;
   logic [SW-1:0] r_lock_id;
   logic          r_out_last;
   assign w_in_last = |(in_last & w_grant);
   assign w_lock    = r_lock;
   assign w_lock_id = r_lock_id;
   assign out_last  = r_out_last;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lock     <= 1'b0;
         r_lock_id  <= '0;
         r_out_last <= 1'b0;
      end else if (w_xfer) begin
         r_lock     <= ~w_in_last;
         r_lock_id  <= w_gid;
         r_out_last <= w_in_last;
      end
   end
`else
   assign w_in_last = 1'b1;
   assign w_lock    = 1'b0;
   assign w_lock_id = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
         r_ptr       <= SW'(N - 1);
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_data;
         r_out_sel   <= w_grant;
         if (w_in_last) r_ptr <= w_gid;
      end else if (w_load) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;
endmodule
